// File: rtl/dcache_wt_if.sv
// CPU-side and RAM-side bus of the write-through data cache.
// The master modport is the cache; the slave modport is its environment (CPU stage plus RAM).
interface dcache_wt_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        flush;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, flush, mem_dout, mem_ack,
    output cpu_dout, cpu_stall, mem_cs, mem_we, mem_addr, mem_din
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_din, flush, mem_dout, mem_ack,
    input  cpu_dout, cpu_stall, mem_cs, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Read hits complete in the request cycle; everything else goes through the RAM handshake.
module dcache_wt #(
  parameter int LINES_LOG2 = 6,
  parameter int TAG_W      = 30 - LINES_LOG2
) (
  input  logic         clk,
  input  logic         rst,
  dcache_wt_if.master  bus
);
  localparam int LINES = 1 << LINES_LOG2;

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic [31:0] r_resp;
  logic        r_we;
  logic        r_cacheable;

  logic [LINES_LOG2-1:0] w_index;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_cacheable;
  logic                  w_hit;
  logic [LINES_LOG2-1:0] w_fill_index;
  logic [TAG_W-1:0]      w_fill_tag;
  logic                  w_accept;
  logic                  w_flush_now;
  logic                  w_store_hit;
  logic                  w_fill;
  logic [LINES-1:0]      w_fill_sel;

  assign w_index      = bus.cpu_addr[LINES_LOG2+1:2];
  assign w_tag        = bus.cpu_addr[31:LINES_LOG2+2];
  assign w_cacheable  = (bus.cpu_addr[31:28] == 4'h0);
  assign w_hit        = w_cacheable && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_fill_index = r_addr[LINES_LOG2+1:2];
  assign w_fill_tag   = r_addr[31:LINES_LOG2+2];

  // Uncached accesses can never hit, so they also never update a line here.
  assign w_store_hit  = w_accept && bus.cpu_we && w_hit;
  assign w_fill       = (r_state == MEM) && bus.mem_ack && !r_we && r_cacheable;

  assign bus.mem_addr = r_addr;
  assign bus.mem_din  = r_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_flush_now   = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.cpu_dout  = 32'h0;
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.flush) begin
          w_flush_now   = 1'b1;
          bus.cpu_stall = bus.cpu_req;
        end else if (bus.cpu_req && !bus.cpu_we && w_hit) begin
          bus.cpu_dout = r_data[w_index];
        end else if (bus.cpu_req) begin
          bus.cpu_stall = 1'b1;
          w_accept      = 1'b1;
          w_state_next  = MEM;
        end
      end
      MEM: begin
        bus.mem_cs    = 1'b1;
        bus.mem_we    = r_we;
        bus.cpu_stall = 1'b1;
        if (bus.mem_ack) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        bus.cpu_dout = r_resp;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (rst) begin
      bus.cpu_stall = bus.cpu_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= 32'h0;
      r_din       <= 32'h0;
      r_we        <= 1'b0;
      r_cacheable <= 1'b0;
      r_resp      <= 32'h0;
    end else begin
      if (w_accept) begin
        r_addr      <= bus.cpu_addr;
        r_din       <= bus.cpu_din;
        r_we        <= bus.cpu_we;
        r_cacheable <= w_cacheable;
      end
      if ((r_state == MEM) && bus.mem_ack) begin
        r_resp <= r_we ? 32'h0 : bus.mem_dout;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_fill_sel
      assign w_fill_sel[gi] = w_fill && (w_fill_index == LINES_LOG2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || w_flush_now) begin
      r_valid <= '0;
    end else begin
      r_valid <= r_valid | w_fill_sel;
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone decide whether a line is live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        r_tag[w_fill_index]  <= w_fill_tag;
        r_data[w_fill_index] <= bus.mem_dout;
      end else if (w_store_hit) begin
        r_data[w_index] <= bus.cpu_din;
      end
    end
  end
endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: table of CPU accesses against a behavioural RAM,
// plus hand sequences for flush-with-request and reset during a RAM access.
module tb_dcache_wt;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_wt_if bus ();

  dcache_wt #(.LINES_LOG2(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] ram [logic [31:0]];
  int          lat      = 2;
  int          wait_cnt = 0;
  int          mem_cnt  = 0;
  logic        last_we;
  logic [31:0] last_addr;
  logic [31:0] last_din;

  // RAM responder: acks after lat MEM cycles; store acks carry junk read data on purpose.
  always @(negedge clk) begin
    if (bus.mem_cs && !bus.mem_ack) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        bus.mem_ack = 1'b1;
        mem_cnt++;
        last_we   = bus.mem_we;
        last_addr = bus.mem_addr;
        last_din  = bus.mem_din;
        if (bus.mem_we) begin
          ram[bus.mem_addr] = bus.mem_din;
          bus.mem_dout = 32'hBAD0BAD0;
        end else begin
          bus.mem_dout = ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : 32'h0;
        end
        wait_cnt = 0;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] din,
                        output logic [31:0] dout, output int cycles, output logic saw_cs);
    bit done;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_addr = addr;
    bus.cpu_din  = din;
    cycles = 0;
    dout   = 32'h0;
    saw_cs = 1'b0;
    done   = 1'b0;
    while (!done) begin
      #2;
      cycles++;
      if (bus.mem_cs) saw_cs = 1'b1;
      if (!bus.cpu_stall) begin
        dout = bus.cpu_dout;
        done = 1'b1;
      end else if (cycles >= 50) begin
        tests++;
        fails++;
        $display("FAIL timeout: got stall after %0d cycles expected completion", cycles);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    int          cycles;
    logic        mem;
    logic        mem_we;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] dout;
    int          cycles;
    logic        saw_cs;
    int          cnt0;

    ram[32'h40]       = 32'hDEADBEEF;
    ram[32'h80]       = 32'h00000011;
    ram[32'h140]      = 32'hCAFE0140;
    ram[32'h10000000] = 32'h00000007;

    // we, addr, din, dout, cycles (lat 2 => miss takes 4), RAM access, RAM write
    vecs.push_back('{1'b0, 32'h40,       32'h0,        32'hDEADBEEF, 4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h40,       32'h0,        32'hDEADBEEF, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h40,       32'h12345678, 32'h0,        4, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 32'h40,       32'h0,        32'h12345678, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h80,       32'h55,       32'h0,        4, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 32'h80,       32'h0,        32'h55,       4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h80,       32'h0,        32'h55,       1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 32'h140,      32'h0,        32'hCAFE0140, 4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h40,       32'h0,        32'h12345678, 4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h140,      32'h0,        32'hCAFE0140, 4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h40,       32'h0,        32'h12345678, 4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h40,       32'h0,        32'h12345678, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h10000000, 32'h41,       32'h0,        4, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 32'h10000000, 32'h0,        32'h41,       4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'h10000000, 32'h0,        32'h41,       4, 1'b1, 1'b0});

    rst          = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h40;
    bus.cpu_din  = 32'h0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_stall", {31'h0, bus.cpu_stall}, 32'h1);
    chk("rst_mem_cs", {31'h0, bus.mem_cs}, 32'h0);
    @(negedge clk);
    rst         = 1'b0;
    bus.cpu_req = 1'b0;
    #2;
    chk("idle_stall", {31'h0, bus.cpu_stall}, 32'h0);
    chk("idle_mem_we", {31'h0, bus.mem_we}, 32'h0);
    chk("idle_mem_addr", bus.mem_addr, 32'h0);
    chk("idle_mem_din", bus.mem_din, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      cnt0 = mem_cnt;
      access(vecs[i].we, vecs[i].addr, vecs[i].din, dout, cycles, saw_cs);
      $display("[TB] txn %0d we=%0b addr=%h dout=%h cycles=%0d ram_access=%0b",
               i, vecs[i].we, vecs[i].addr, dout, cycles, saw_cs);
      chk($sformatf("v%0d_dout", i), dout, vecs[i].dout);
      chk($sformatf("v%0d_cycles", i), cycles, vecs[i].cycles);
      chk($sformatf("v%0d_saw_cs", i), {31'h0, saw_cs}, {31'h0, vecs[i].mem});
      chk($sformatf("v%0d_mem_cnt", i), mem_cnt - cnt0, vecs[i].mem ? 32'd1 : 32'd0);
      if (vecs[i].mem) begin
        chk($sformatf("v%0d_mem_addr", i), last_addr, vecs[i].addr);
        chk($sformatf("v%0d_mem_we", i), {31'h0, last_we}, {31'h0, vecs[i].mem_we});
        if (vecs[i].we) chk($sformatf("v%0d_mem_din", i), last_din, vecs[i].din);
      end
    end

    // Flush with a simultaneous load of a cached line: stall that cycle, then a miss.
    cnt0 = mem_cnt;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h40;
    bus.flush    = 1'b1;
    #2;
    chk("flush_stall", {31'h0, bus.cpu_stall}, 32'h1);
    chk("flush_mem_cs", {31'h0, bus.mem_cs}, 32'h0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    access(1'b0, 32'h40, 32'h0, dout, cycles, saw_cs);
    $display("[TB] txn flush-load addr=00000040 dout=%h cycles=%0d ram_access=%0b", dout, cycles, saw_cs);
    chk("flush_load_dout", dout, 32'h12345678);
    chk("flush_load_cycles", cycles, 32'd4);
    chk("flush_load_mem_cnt", mem_cnt - cnt0, 32'd1);

    // Reset while a miss on 0x140 sits in MEM; line 16 (0x40) must be invalid afterwards.
    lat  = 10;
    cnt0 = mem_cnt;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h140;
    #2;
    chk("rstmem_idle_stall", {31'h0, bus.cpu_stall}, 32'h1);
    @(negedge clk);
    #2;
    chk("rstmem_cs_before", {31'h0, bus.mem_cs}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rstmem_stall", {31'h0, bus.cpu_stall}, 32'h1);
    @(negedge clk);
    rst         = 1'b0;
    bus.cpu_req = 1'b0;
    #2;
    chk("rstmem_cs_after", {31'h0, bus.mem_cs}, 32'h0);
    chk("rstmem_mem_addr", bus.mem_addr, 32'h0);
    chk("rstmem_no_ack", mem_cnt - cnt0, 32'd0);
    $display("[TB] txn reset-during-mem addr=00000140 mem_cs=%0b", bus.mem_cs);
    lat  = 2;
    cnt0 = mem_cnt;
    access(1'b0, 32'h40, 32'h0, dout, cycles, saw_cs);
    $display("[TB] txn post-reset-load addr=00000040 dout=%h cycles=%0d ram_access=%0b", dout, cycles, saw_cs);
    chk("rstmem_load_dout", dout, 32'h12345678);
    chk("rstmem_load_cycles", cycles, 32'd4);
    chk("rstmem_load_mem_cnt", mem_cnt - cnt0, 32'd1);
    access(1'b0, 32'h40, 32'h0, dout, cycles, saw_cs);
    $display("[TB] txn refill-hit addr=00000040 dout=%h cycles=%0d ram_access=%0b", dout, cycles, saw_cs);
    chk("refill_hit_dout", dout, 32'h12345678);
    chk("refill_hit_cycles", cycles, 32'd1);
    @(negedge clk);
    bus.cpu_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache sitting between the CPU memory stage and the multi-cycle data RAM (`cs`/`we`/`ack` handshake). Read hits complete in the request cycle with no memory traffic. Misses, all writes and every access to the uncached I/O region (simulation UART at 0x10000000) are forwarded to RAM. The cache holds the CPU stalled until the forwarded access is acknowledged.

## Interface
Parameters:
- `LINES_LOG2`, 6: log2 of line count. One 32-bit word per line.
- `TAG_W`, 30-LINES_LOG2: tag width, derived; do not override.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_req` in 1: access request; held with address/data stable until a cycle with `cpu_stall`=0.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address; bits [1:0] ignored (word accesses only).
- `cpu_din` in 32: store data.
- `cpu_dout` out 32: load data; valid only in the completing cycle.
- `cpu_stall` out 1: request not yet complete.
- `flush` in 1: invalidate all lines.
- `mem_cs` out 1: RAM chip select; held until `mem_ack`.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out 32: RAM address.
- `mem_din` out 32: RAM write data.
- `mem_dout` in 32: RAM read data; valid in the `mem_ack` cycle.
- `mem_ack` in 1: RAM completion pulse.

## Operation
- Address split: index = addr[LINES_LOG2+1:2], tag = addr[31:LINES_LOG2+2].
- Cacheable iff addr[31:28]==0. Uncached accesses never look up, fill or update lines.
- Per line: valid bit, tag, 32-bit data. hit = cacheable & valid[index] & tag match.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - `flush` set: clear all valid bits, `cpu_stall`=cpu_req, stay in IDLE. Flush has priority over a request.
  - Else if cpu_req & !cpu_we & hit: `cpu_dout`=line data, `cpu_stall`=0, stay in IDLE.
  - Else if cpu_req: latch addr/we/din/cacheable, go to MEM.
  - Store hit: line data updated with cpu_din on the IDLE→MEM edge. Store miss: no allocate.
- MEM: `mem_cs`=1; `mem_we`/`mem_addr`/`mem_din` driven from the latched values. `cpu_stall`=1.
  - On `mem_ack`: load data latched into a response register. A cacheable load fills the line (valid=1, tag, data). Go to RESP.
- RESP: `cpu_stall`=0; `cpu_dout`=response register (0 for stores). Next state IDLE unconditionally.
- `flush` outside IDLE is ignored. `mem_ack` outside MEM is ignored.

## Timing
- Reset values: state IDLE, all valid=0, `mem_cs`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, response register 0. `cpu_stall`=cpu_req during reset.
- Read hit: 0 extra cycles; completes in the request cycle.
- Miss, store, or uncached access: 1 IDLE cycle, then N MEM cycles ending with the `mem_ack` cycle, then 1 RESP cycle. Total N+2 cycles.
- `mem_cs` rises on the clock after the request is accepted in IDLE. It drops on the clock after `mem_ack`.
- A new request may be presented in the cycle after RESP. Back-to-back hits complete one per cycle.
- `rst` mid-MEM: `mem_cs` is 0 the next cycle, all lines are invalid, and no fill occurs.

## Test plan
- Reset, RAM[0x40]=0xDEADBEEF, load 0x40 → `mem_cs` asserted with `mem_we`=0, RESP `cpu_dout`=0xDEADBEEF. Repeat load of 0x40 → `cpu_stall`=0 in the same cycle, `mem_cs` stays 0.
- After the above, store 0x12345678 to 0x40 → RAM write issued with `mem_din`=0x12345678. Load 0x40 → hit returning 0x12345678, no RAM access.
- Store 0x55 to 0x80 (miss), then load 0x80 → the load misses and reads RAM (no-allocate verified).
- Load 0x40, load 0x140, load 0x40 (both index 16) → all three miss and each issues a RAM read.
- Store 0x41 to 0x10000000 → RAM write forwarded. Load 0x10000000 twice → both go to RAM, no hit.
- Fill 0x40; assert `flush` with a simultaneous load of 0x40 → stall that cycle, then a miss. Separately, assert `rst` during MEM → `mem_cs`=0 next cycle, and a later load of 0x40 misses.
